// File: rtl/mem_map_controller.sv
// rtl/mem_map_controller.sv - data-side req/ready memory controller for BRAM, PRAM and N I/O channels
module mem_map_controller #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 18,
  parameter int                N_IO      = 4,
  parameter logic [ADDR_W-1:0] PRAM_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] IO_BASE   = 16'h2000,
  parameter int                TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  input  logic [ADDR_W-1:0]      cpu_iaddr,
  output logic [INSTR_W-1:0]     cpu_instr,
  output logic [ADDR_W-1:0]      main_iaddr,
  input  logic [INSTR_W-1:0]     main_instr,
  output logic [ADDR_W-1:0]      main_addr,
  output logic [DATA_W-1:0]      main_wdata,
  output logic                   main_we,
  input  logic [DATA_W-1:0]      main_rdata,
  output logic [DATA_W-1:0]      pram_q,
  output logic                   pram_we,
  output logic [N_IO-1:0]        io_sel,
  output logic                   io_we,
  output logic [DATA_W-1:0]      io_wdata,
  input  logic [N_IO-1:0]        io_ack,
  input  logic [N_IO*DATA_W-1:0] io_rdata,
  output logic                   err,
  input  logic                   err_clr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_WAIT    = 3'd2,
    S_IO_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_cpu_ready;
  logic [ADDR_W-1:0]   r_main_addr;
  logic [DATA_W-1:0]   r_main_wdata;
  logic                r_main_we;
  logic [DATA_W-1:0]   r_pram_q;
  logic                r_pram_we;
  logic [N_IO-1:0]     r_io_sel;
  logic                r_io_we;
  logic [DATA_W-1:0]   r_io_wdata;
  logic                r_err;
  logic [7:0]          r_tcnt;
  logic                r_is_pram;

  logic [ADDR_W-1:0]   w_io_off;
  logic [N_IO-1:0]     w_io_onehot;
  logic                w_is_io;
  logic                w_is_pram;
  logic                w_accept;
  logic                w_ack_hit;
  logic                w_timeout;
  logic                w_io_done;
  logic                w_err_set;
  logic [DATA_W-1:0]   w_io_rdata;

  // Instruction fetch is a pure pass-through, untouched by the FSM or reset.
  assign main_iaddr = cpu_iaddr;
  assign cpu_instr  = main_instr;

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ready  = r_cpu_ready;
  assign main_addr  = r_main_addr;
  assign main_wdata = r_main_wdata;
  assign main_we    = r_main_we;
  assign pram_q     = r_pram_q;
  assign pram_we    = r_pram_we;
  assign io_sel     = r_io_sel;
  assign io_we      = r_io_we;
  assign io_wdata   = r_io_wdata;
  assign err        = r_err;

  // Address decode: the I/O window has priority over the PRAM register.
  always_comb begin
    w_io_off    = cpu_addr - IO_BASE;
    w_is_io     = (cpu_addr >= IO_BASE) && (w_io_off < ADDR_W'(N_IO));
    w_is_pram   = !w_is_io && (cpu_addr == PRAM_ADDR);
    w_io_onehot = '0;
    for (int i = 0; i < N_IO; i++) begin
      w_io_onehot[i] = (w_io_off == ADDR_W'(i));
    end
  end

  // Read data of the currently selected channel and completion qualifiers.
  always_comb begin
    w_io_rdata = '0;
    for (int i = 0; i < N_IO; i++) begin
      if (r_io_sel[i]) begin
        w_io_rdata = w_io_rdata | io_rdata[i*DATA_W +: DATA_W];
      end
    end
    w_accept  = (r_state == S_IDLE) && cpu_req;
    w_ack_hit = |(io_ack & r_io_sel);
    w_timeout = (r_tcnt == 8'(TIMEOUT - 1));
    w_io_done = (r_state == S_IO_WAIT) && (w_ack_hit || w_timeout);
    w_err_set = (r_state == S_IO_WAIT) && !w_ack_hit && w_timeout;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cpu_req) w_next = w_is_io ? S_IO_WAIT : S_ACCESS;
      S_ACCESS:  w_next = S_WAIT;
      S_WAIT:    w_next = S_RESP;
      S_IO_WAIT: if (w_io_done) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: strobes, latched request, response capture and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_main_addr  <= '0;
      r_main_wdata <= '0;
      r_main_we    <= 1'b0;
      r_pram_q     <= '0;
      r_pram_we    <= 1'b0;
      r_io_sel     <= '0;
      r_io_we      <= 1'b0;
      r_io_wdata   <= '0;
      r_tcnt       <= '0;
      r_is_pram    <= 1'b0;
    end else begin
      r_main_we <= 1'b0;
      r_pram_we <= 1'b0;
      // I/O completes ready on the completion edge; memory paths raise it
      // one edge after capture so ready overlaps the first IDLE cycle.
      r_cpu_ready <= w_io_done || ((r_state == S_RESP) && !r_cpu_ready);
      if (w_accept) begin
        if (w_is_io) begin
          r_io_sel   <= w_io_onehot;
          r_io_we    <= cpu_we;
          r_io_wdata <= cpu_wdata;
          r_tcnt     <= '0;
        end else begin
          r_is_pram    <= w_is_pram;
          r_main_addr  <= cpu_addr;
          r_main_wdata <= cpu_wdata;
          if (w_is_pram) begin
            r_pram_we <= cpu_we;
            if (cpu_we) r_pram_q <= cpu_wdata;
          end else begin
            r_main_we <= cpu_we;
          end
        end
      end
      if (r_state == S_WAIT) begin
        r_cpu_rdata <= r_is_pram ? r_pram_q : main_rdata;
      end
      if (r_state == S_IO_WAIT) begin
        if (w_ack_hit) begin
          r_cpu_rdata <= w_io_rdata;
          r_io_sel    <= '0;
          r_io_we     <= 1'b0;
        end else if (w_timeout) begin
          r_cpu_rdata <= '1;
          r_io_sel    <= '0;
          r_io_we     <= 1'b0;
        end else begin
          r_tcnt <= r_tcnt + 8'd1;
        end
      end
    end
  end

  // Sticky timeout flag; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

endmodule

// File: tb/tb_mem_map_controller.sv
// tb/tb_mem_map_controller.sv - directed self-checking bench for mem_map_controller
module tb_mem_map_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [15:0] cpu_iaddr;
  logic [17:0] cpu_instr;
  logic [15:0] main_iaddr;
  logic [17:0] main_instr;
  logic [15:0] main_addr;
  logic [15:0] main_wdata;
  logic        main_we;
  logic [15:0] main_rdata;
  logic [15:0] pram_q;
  logic        pram_we;
  logic [3:0]  io_sel;
  logic        io_we;
  logic [15:0] io_wdata;
  logic [3:0]  io_ack;
  logic [63:0] io_rdata;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int pw_cnt = 0;
  int sel_cycles;
  logic [3:0] first_sel;
  logic ign_pulse;
  logic [15:0] mem [0:1023];

  mem_map_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_iaddr(cpu_iaddr), .cpu_instr(cpu_instr),
    .main_iaddr(main_iaddr), .main_instr(main_instr),
    .main_addr(main_addr), .main_wdata(main_wdata), .main_we(main_we), .main_rdata(main_rdata),
    .pram_q(pram_q), .pram_we(pram_we),
    .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // BRAM model with one-cycle read latency, plus strobe-cycle counters.
  always @(posedge clk) begin
    if (main_we) mem[main_addr[9:0]] <= main_wdata;
    main_rdata <= mem[main_addr[9:0]];
    if (main_we) we_cnt <= we_cnt + 1;
    if (pram_we) pw_cnt <= pw_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access; lat = edges from acceptance to the edge that shows ready.
  task automatic access(input logic [15:0] addr, input logic we, input logic [15:0] wd,
                        input int ack_k, input int ack_ch,
                        output int lat, output logic [15:0] rd);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
    lat = -1; rd = '0; sel_cycles = 0; first_sel = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) first_sel = io_sel;
      if (io_sel != 4'b0000) sel_cycles++;
      if (cpu_ready) begin
        lat = n - 1;
        rd = cpu_rdata;
        break;
      end
      if (ign_pulse && n == 1) io_ack[1] = 1'b1;
      if (ign_pulse && n == 2) io_ack[1] = 1'b0;
      if (n == ack_k) io_ack[ack_ch] = 1'b1;
    end
    cpu_req = 1'b0;
    io_ack = '0;
    if (lat < 0) check("ready_bound", 32'd0, 32'd1);
  endtask

  int lat;
  logic [15:0] rd;
  int we0, pw0;

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_iaddr = 16'h0042; main_instr = 18'h2ABCD; io_ack = '0; err_clr = 1'b0;
    ign_pulse = 1'b0;
    io_rdata = {16'h3C3C, 16'hA5A5, 16'h1111, 16'h0F0F};
    repeat (2) @(posedge clk);
    #1;
    check("instr_in_reset_addr", {16'h0, main_iaddr}, 32'h0042);
    check("instr_in_reset_data", {14'h0, cpu_instr}, 32'h2ABCD);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'h0, cpu_ready}, 32'd0);
    check("rst_io_sel", {28'h0, io_sel}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_pram_q", {16'h0, pram_q}, 32'd0);
    check("rst_main_we", {31'h0, main_we}, 32'd0);
    check("rst_rdata", {16'h0, cpu_rdata}, 32'd0);

    // main memory write then read
    we0 = we_cnt; pw0 = pw_cnt;
    access(16'h0100, 1'b1, 16'hBEEF, 0, 0, lat, rd);
    check("wr_main_lat", lat, 32'd3);
    check("wr_main_we_cycles", we_cnt - we0, 32'd1);
    check("wr_main_no_pram_we", pw_cnt - pw0, 32'd0);
    access(16'h0100, 1'b0, 16'h0000, 0, 0, lat, rd);
    check("rd_main_lat", lat, 32'd3);
    check("rd_main_data", {16'h0, rd}, 32'h0000BEEF);

    // PRAM write and read back
    cpu_iaddr = 16'h1234; main_instr = 18'h15A5A;
    we0 = we_cnt; pw0 = pw_cnt;
    access(16'h0000, 1'b1, 16'h1234, 0, 0, lat, rd);
    check("wr_pram_lat", lat, 32'd3);
    check("wr_pram_we_cycles", pw_cnt - pw0, 32'd1);
    check("wr_pram_no_main_we", we_cnt - we0, 32'd0);
    check("pram_q", {16'h0, pram_q}, 32'h1234);
    check("instr_track_addr", {16'h0, main_iaddr}, 32'h1234);
    check("instr_track_data", {14'h0, cpu_instr}, 32'h15A5A);
    we0 = we_cnt;
    access(16'h0000, 1'b0, 16'h0000, 0, 0, lat, rd);
    check("rd_pram_data", {16'h0, rd}, 32'h1234);
    check("rd_pram_no_main_we", we_cnt - we0, 32'd0);

    // I/O read, ack on third edge, stray ack on channel 1 ignored
    ign_pulse = 1'b1;
    access(16'h2002, 1'b0, 16'h0000, 3, 2, lat, rd);
    ign_pulse = 1'b0;
    check("io_sel_onehot", {28'h0, first_sel}, 32'b0100);
    check("io_sel_cycles", sel_cycles, 32'd3);
    check("io_lat", lat, 32'd3);
    check("io_rdata", {16'h0, rd}, 32'hA5A5);
    check("io_err_clear", {31'h0, err}, 32'd0);
    @(posedge clk); #1;
    check("io_ready_one_cycle", {31'h0, cpu_ready}, 32'd0);

    // I/O timeout: all-ones data and sticky error
    access(16'h2003, 1'b0, 16'h0000, 0, 3, lat, rd);
    check("to_lat", lat, 32'd16);
    check("to_rdata", {16'h0, rd}, 32'hFFFF);
    check("to_err_set", {31'h0, err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", {31'h0, err}, 32'd1);

    // asynchronous reset in the middle of an I/O wait
    @(posedge clk); #1;
    cpu_addr = 16'h2001; cpu_we = 1'b1; cpu_wdata = 16'h7777; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("mid_io_sel", {28'h0, io_sel}, 32'b0010);
    check("mid_io_we", {31'h0, io_we}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_io_sel", {28'h0, io_sel}, 32'd0);
    check("mid_rst_ready", {31'h0, cpu_ready}, 32'd0);
    check("mid_rst_err", {31'h0, err}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(16'h0100, 1'b0, 16'h0000, 0, 0, lat, rd);
    check("post_rst_lat", lat, 32'd3);
    check("post_rst_data", {16'h0, rd}, 32'hBEEF);

    // timeout while err_clr held: set wins, then clear
    err_clr = 1'b1;
    access(16'h2003, 1'b0, 16'h0000, 0, 3, lat, rd);
    check("setclr_err_set", {31'h0, err}, 32'd1);
    @(posedge clk); #1;
    check("setclr_err_cleared", {31'h0, err}, 32'd0);
    err_clr = 1'b0;

    // ack on the timeout edge wins
    access(16'h2003, 1'b0, 16'h0000, 16, 3, lat, rd);
    check("ack16_lat", lat, 32'd16);
    check("ack16_rdata", {16'h0, rd}, 32'h3C3C);
    check("ack16_no_err", {31'h0, err}, 32'd0);

    // just past the I/O window goes to main memory
    we0 = we_cnt;
    access(16'h2004, 1'b1, 16'h5555, 0, 0, lat, rd);
    check("oob_lat", lat, 32'd3);
    check("oob_no_io_sel", sel_cycles, 32'd0);
    check("oob_main_we", we_cnt - we0, 32'd1);
    access(16'h2004, 1'b0, 16'h0000, 0, 0, lat, rd);
    check("oob_read", {16'h0, rd}, 32'h5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_map_controller.md
# mem_map_controller

Parametrised data-side memory controller between the CPU and the main block RAM, PRAM register and a bank of memory-mapped I/O devices. Successor to the combinational decoder: every data access is a req/ready transaction with fixed BRAM latency, PRAM is readable, and N I/O channels use a per-channel ack handshake with a timeout. The instruction fetch path stays a combinational pass-through.

## Interface
- DATA_W, 16, data width
- ADDR_W, 16, data/instruction address width
- INSTR_W, 18, instruction width
- N_IO, 4, I/O channel count (1..16)
- PRAM_ADDR, 16'h0000, PRAM register address
- IO_BASE, 16'h2000, channel i lives at IO_BASE+i
- TIMEOUT, 16, max IO_WAIT cycles before abort (2..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- cpu_req  in  1  access request (level)
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  data address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_iaddr  in  ADDR_W  instruction address
- cpu_instr  out  INSTR_W  instruction = main_instr
- main_iaddr  out  ADDR_W  = cpu_iaddr
- main_instr  in  INSTR_W  BRAM instruction port data
- main_addr, main_wdata  out  ADDR_W, DATA_W  BRAM data port
- main_we  out  1  BRAM write enable
- main_rdata  in  DATA_W  BRAM read data, 1-cycle latency
- pram_q  out  DATA_W  PRAM register contents
- pram_we  out  1  pulse when PRAM written
- io_sel  out  N_IO  one-hot channel select
- io_we  out  1  write qualifier, held with io_sel
- io_wdata  out  DATA_W  held with io_sel
- io_ack  in  N_IO  per-channel completion
- io_rdata  in  N_IO*DATA_W  channel i at [i*DATA_W +: DATA_W]
- err  out  1  sticky timeout flag
- err_clr  in  1  synchronous clear of err

## Operation
- Decode (IDLE only, priority order): IO_BASE <= addr < IO_BASE+N_IO -> I/O channel addr-IO_BASE; addr == PRAM_ADDR -> PRAM; else main memory.
- States: IDLE, ACCESS, WAIT, IO_WAIT, RESP. Requests accepted only in IDLE; cpu_addr/we/wdata latched at acceptance edge.
- Main: IDLE->ACCESS (main_addr/main_wdata driven, main_we=cpu_we for this cycle only) ->WAIT ->RESP (cpu_rdata <= main_rdata captured at WAIT exit; writes return main_rdata too, don't-care) ->IDLE.
- PRAM: same path; pram_q <= wdata and pram_we=1 in ACCESS on write; main_we stays 0; read returns pram_q.
- I/O: IDLE->IO_WAIT; io_sel one-hot, io_we, io_wdata driven from the acceptance edge, held constant until exit. Each edge in IO_WAIT: io_ack of selected channel high -> cpu_rdata <= its io_rdata slice, ->RESP. Acks of unselected channels ignored. No ack by the TIMEOUT-th IO_WAIT edge -> cpu_rdata <= all ones, err <= 1, ->RESP. Ack on the timeout edge wins (no error).
- RESP: cpu_ready=1 one cycle, ->IDLE. CPU must drop cpu_req on the edge it samples ready, else request re-accepted in IDLE.
- err_clr clears err; simultaneous set and clear -> set wins.
- Instruction path: pure wires, independent of FSM and reset.

## Timing
- Reset (async, any state): state IDLE; cpu_rdata, cpu_ready, main_addr, main_wdata, main_we, pram_q, pram_we, io_sel, io_we, io_wdata, err, timeout counter all 0. Mid-transaction reset drops io_sel/main_we immediately; no ready issued.
- Main/PRAM: req sampled at edge T -> main_we/pram_we high T..T+1 -> cpu_ready high T+3..T+4. Throughput one access per 4 cycles (next acceptance at T+4).
- I/O: req at T, ack sampled at edge T+k (1 <= k <= TIMEOUT) -> io_sel low and cpu_ready high after T+k+1... precisely: io_sel high T..T+k, cpu_ready high T+k..T+k+1. Timeout: ready high T+TIMEOUT..T+TIMEOUT+1.
- All non-instruction outputs registered.

## Test plan
- Reset mid-IO_WAIT with io_sel=0010 -> io_sel, cpu_ready, err all 0 immediately; next req accepted normally.
- Write 16'hBEEF to 16'h0100 at T, then read 16'h0100 -> main_we one cycle, cpu_ready at T+3, read returns 16'hBEEF.
- Write 16'h1234 to PRAM_ADDR -> pram_we one cycle, main_we never high, pram_q=16'h1234; read back returns 16'h1234.
- Read 16'h2002, io_ack[2] asserted 3 edges later with slice 16'hA5A5 -> io_sel=0100 held 3 cycles, cpu_rdata=16'hA5A5, ready one cycle, err 0; io_ack[1] pulse during wait ignored.
- Read 16'h2003, never ack -> ready after 16 edges, cpu_rdata=16'hFFFF, err=1 stays until err_clr; ack on 16th edge instead -> no error.
- Address 16'h2004 with N_IO=4 -> routed to main memory; instruction port tracks cpu_iaddr combinationally throughout.
